// File: rtl/instruction_loader.sv
// Byte-stream program loader: packs high/low byte pairs into 14-bit instruction
// words and writes them to consecutive program-memory addresses.
module instruction_loader #(
  parameter int ADDR_W   = 10,
  parameter int PROG_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [13:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [5:0]        r_hiReg;
  logic [ADDR_W-1:0] r_memAddr;
  logic [13:0]       r_memWdata;

  logic w_loadStart;
  logic w_latchHi;
  logic w_latchLo;
  logic w_incAddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Outputs are pure state decodes; the datapath strobes are squashed by abort
  // so an aborted cycle leaves address and data untouched.
  always_comb begin
    w_nextState = r_state;
    w_loadStart = 1'b0;
    w_latchHi   = 1'b0;
    w_latchLo   = 1'b0;
    w_incAddr   = 1'b0;
    byte_ready  = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = HI;
          w_loadStart = 1'b1;
        end
      end
      HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (byte_in[7:6] == 2'b00) begin
            w_nextState = LO;
            w_latchHi   = 1'b1;
          end else begin
            w_nextState = ERR;
          end
        end
      end
      LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          w_nextState = WRITE;
          w_latchLo   = 1'b1;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (r_memAddr == LAST_ADDR) begin
          w_nextState = DONE;
        end else begin
          w_nextState = HI;
          w_incAddr   = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_nextState = HI;
          w_loadStart = 1'b1;
        end
      end
      ERR: begin
        err = 1'b1;
        if (start) begin
          w_nextState = HI;
          w_loadStart = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (abort) begin
      w_nextState = IDLE;
      w_loadStart = 1'b0;
      w_latchHi   = 1'b0;
      w_latchLo   = 1'b0;
      w_incAddr   = 1'b0;
    end
  end

  // The address increment happens only when leaving WRITE for another word, so
  // the final address PROG_LEN-1 is never incremented and cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hiReg    <= 6'd0;
      r_memAddr  <= '0;
      r_memWdata <= 14'd0;
    end else begin
      if (w_loadStart) begin
        r_memAddr <= '0;
      end else if (w_incAddr) begin
        r_memAddr <= r_memAddr + ADDR_W'(1);
      end
      if (w_latchHi) begin
        r_hiReg <= byte_in[5:0];
      end
      if (w_latchLo) begin
        r_memWdata <= {r_hiReg, byte_in};
      end
    end
  end

  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a 4-word loader and a 1-word loader
// share the byte link; every memory write is popped from a per-DUT scoreboard.
module tb_instruction_loader;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cycle = 0;

   logic [7:0] byteIn;
   logic byteValid;
   logic aStart, aAbort, bStart, bAbort;

   logic aReady, aWe, aBusy, aDone, aErr;
   logic [3:0] aAddr;
   logic [13:0] aWdata;
   logic bReady, bWe, bBusy, bDone, bErr;
   logic [9:0] bAddr;
   logic [13:0] bWdata;

   logic [23:0] expA[$];
   logic [23:0] expB[$];
   logic [23:0] eA, eB;
   int aWeCyc[$];
   int aWeCount = 0;
   int bWeCount = 0;
   int savedCount;

   instruction_loader #(.ADDR_W(4), .PROG_LEN(4)) dutA (
      .clk(clk), .reset(reset), .start(aStart), .abort(aAbort),
      .byte_in(byteIn), .byte_valid(byteValid), .byte_ready(aReady),
      .mem_we(aWe), .mem_addr(aAddr), .mem_wdata(aWdata),
      .busy(aBusy), .done(aDone), .err(aErr)
   );

   instruction_loader #(.ADDR_W(10), .PROG_LEN(1)) dutB (
      .clk(clk), .reset(reset), .start(bStart), .abort(bAbort),
      .byte_in(byteIn), .byte_valid(byteValid), .byte_ready(bReady),
      .mem_we(bWe), .mem_addr(bAddr), .mem_wdata(bWdata),
      .busy(bBusy), .done(bDone), .err(bErr)
   );

   // Cycle stamp used to measure spacing between write strobes.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one byte and hold it until the selected loader accepts it; returns #1 after the transfer edge.
   task automatic applyStimulus(input bit sel, input logic [7:0] b);
      bit got;
      got = 1'b0;
      byteIn = b;
      byteValid = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         if ((sel ? bReady : aReady) === 1'b1) begin
            @(posedge clk);
            #1;
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checkOutput("byte_accepted", 32'(got), 32'd1);
   endtask

   task automatic pulseStart(input bit sel);
      @(negedge clk);
      if (sel) bStart = 1'b1;
      else aStart = 1'b1;
      @(posedge clk);
      #1;
      aStart = 1'b0;
      bStart = 1'b0;
   endtask

   task automatic checkAllZeroA(input string tag);
      checkOutput({tag, "_busy"}, 32'(aBusy), 32'd0);
      checkOutput({tag, "_ready"}, 32'(aReady), 32'd0);
      checkOutput({tag, "_we"}, 32'(aWe), 32'd0);
      checkOutput({tag, "_addr"}, 32'(aAddr), 32'd0);
      checkOutput({tag, "_wdata"}, 32'(aWdata), 32'd0);
      checkOutput({tag, "_done"}, 32'(aDone), 32'd0);
      checkOutput({tag, "_err"}, 32'(aErr), 32'd0);
   endtask

   // Scoreboard monitors: every write strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (aWe === 1'b1) begin
         aWeCount++;
         aWeCyc.push_back(cycle);
         checkOutput("a_sb_nonempty", 32'(expA.size() != 0), 32'd1);
         if (expA.size() != 0) begin
            eA = expA.pop_front();
            checkOutput("a_wr_addr", 32'(aAddr), 32'(eA[23:14]));
            checkOutput("a_wr_data", 32'(aWdata), 32'(eA[13:0]));
         end
      end
      if (bWe === 1'b1) begin
         bWeCount++;
         checkOutput("b_sb_nonempty", 32'(expB.size() != 0), 32'd1);
         if (expB.size() != 0) begin
            eB = expB.pop_front();
            checkOutput("b_wr_addr", 32'(bAddr), 32'(eB[23:14]));
            checkOutput("b_wr_data", 32'(bWdata), 32'(eB[13:0]));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1;
      aStart = 1'b0; aAbort = 1'b0; bStart = 1'b0; bAbort = 1'b0;
      byteIn = 8'h00; byteValid = 1'b0;
      repeat (2) @(negedge clk);
      checkAllZeroA("rst");
      reset = 1'b0;
      $display("[TB] reset released");

      // Single-word loader: one write of 0x2FA5 at 0, then done
      pulseStart(1'b1);
      checkOutput("b_busy_after_start", 32'(bBusy), 32'd1);
      checkOutput("b_ready_after_start", 32'(bReady), 32'd1);
      applyStimulus(1'b1, 8'h2F);
      expB.push_back({10'd0, 14'h2FA5});
      applyStimulus(1'b1, 8'hA5);
      byteValid = 1'b0;
      checkOutput("b_we_in_write", 32'(bWe), 32'd1);
      checkOutput("b_addr_in_write", 32'(bAddr), 32'd0);
      checkOutput("b_wdata_in_write", 32'(bWdata), 32'h2FA5);
      @(posedge clk); #1;
      checkOutput("b_done", 32'(bDone), 32'd1);
      checkOutput("b_busy_after_done", 32'(bBusy), 32'd0);
      checkOutput("b_we_after_done", 32'(bWe), 32'd0);
      checkOutput("b_err", 32'(bErr), 32'd0);

      // Four-word load; gaps on the first word, continuous valid afterwards
      $display("[TB] full load");
      pulseStart(1'b0);
      applyStimulus(1'b0, 8'h00);
      byteValid = 1'b0;
      repeat (2) @(negedge clk);
      expA.push_back({10'd0, 14'h0001});
      applyStimulus(1'b0, 8'h01);
      byteValid = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 8'h07);
      expA.push_back({10'd1, 14'h07FF});
      applyStimulus(1'b0, 8'hFF);
      applyStimulus(1'b0, 8'h38);
      expA.push_back({10'd2, 14'h3800});
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h3F);
      expA.push_back({10'd3, 14'h3FFF});
      applyStimulus(1'b0, 8'hFF);
      byteValid = 1'b0;
      checkOutput("a_we_last", 32'(aWe), 32'd1);
      checkOutput("a_addr_last", 32'(aAddr), 32'd3);
      @(posedge clk); #1;
      checkOutput("a_done", 32'(aDone), 32'd1);
      checkOutput("a_busy_done", 32'(aBusy), 32'd0);
      checkOutput("a_ready_done", 32'(aReady), 32'd0);
      checkOutput("a_we_count", 32'(aWeCount), 32'd4);
      if (aWeCyc.size() >= 4) begin
         checkOutput("a_spacing_1_2", 32'(aWeCyc[2] - aWeCyc[1]), 32'd3);
         checkOutput("a_spacing_2_3", 32'(aWeCyc[3] - aWeCyc[2]), 32'd3);
      end

      // Bytes offered while DONE are ignored
      savedCount = aWeCount;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         byteValid = i[0];
         byteIn = 8'($urandom);
      end
      @(negedge clk);
      byteValid = 1'b0;
      checkOutput("a_done_hold", 32'(aDone), 32'd1);
      checkOutput("a_ready_in_done", 32'(aReady), 32'd0);
      checkOutput("a_addr_in_done", 32'(aAddr), 32'd3);
      checkOutput("a_no_write_in_done", 32'(aWeCount), 32'(savedCount));

      // Restart from DONE, then a framing error on the second high byte
      $display("[TB] framing error");
      pulseStart(1'b0);
      checkOutput("a_done_cleared", 32'(aDone), 32'd0);
      checkOutput("a_busy_restart", 32'(aBusy), 32'd1);
      checkOutput("a_addr_restart", 32'(aAddr), 32'd0);
      savedCount = aWeCount;
      applyStimulus(1'b0, 8'h12);
      expA.push_back({10'd0, 14'h1234});
      applyStimulus(1'b0, 8'h34);
      applyStimulus(1'b0, 8'h40);
      byteValid = 1'b0;
      checkOutput("a_err_set", 32'(aErr), 32'd1);
      checkOutput("a_busy_err", 32'(aBusy), 32'd0);
      checkOutput("a_ready_err", 32'(aReady), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         byteValid = ~i[0];
         byteIn = 8'h00;
      end
      @(negedge clk);
      byteValid = 1'b0;
      checkOutput("a_err_hold", 32'(aErr), 32'd1);
      checkOutput("a_addr_err", 32'(aAddr), 32'd1);
      checkOutput("a_one_write_before_err", 32'(aWeCount), 32'(savedCount + 1));
      pulseStart(1'b0);
      checkOutput("a_err_cleared", 32'(aErr), 32'd0);
      checkOutput("a_addr_after_err", 32'(aAddr), 32'd0);
      checkOutput("a_ready_after_err", 32'(aReady), 32'd1);
      applyStimulus(1'b0, 8'h01);

      // Abort while waiting for a low byte
      $display("[TB] abort");
      @(negedge clk);
      byteValid = 1'b0;
      aAbort = 1'b1;
      @(posedge clk); #1;
      checkOutput("a_abort_lo_busy", 32'(aBusy), 32'd0);
      checkOutput("a_abort_lo_ready", 32'(aReady), 32'd0);
      checkOutput("a_abort_lo_we", 32'(aWe), 32'd0);
      checkOutput("a_abort_lo_wdata", 32'(aWdata), 32'h1234);
      @(negedge clk);
      aAbort = 1'b0;
      savedCount = aWeCount;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         byteValid = ~i[0];
      end
      @(negedge clk);
      byteValid = 1'b0;
      checkOutput("a_idle_ignores", 32'(aBusy), 32'd0);
      checkOutput("a_idle_no_write", 32'(aWeCount), 32'(savedCount));

      // Start while busy is ignored, then abort coincident with a low-byte transfer
      pulseStart(1'b0);
      applyStimulus(1'b0, 8'h00);
      expA.push_back({10'd0, 14'h0005});
      applyStimulus(1'b0, 8'h05);
      byteValid = 1'b0;
      @(posedge clk); #1;
      pulseStart(1'b0);
      checkOutput("a_start_busy_addr", 32'(aAddr), 32'd1);
      checkOutput("a_start_busy_busy", 32'(aBusy), 32'd1);
      applyStimulus(1'b0, 8'h15);
      @(negedge clk);
      byteIn = 8'h99;
      byteValid = 1'b1;
      aAbort = 1'b1;
      @(posedge clk); #1;
      checkOutput("a_abort_xfer_we", 32'(aWe), 32'd0);
      checkOutput("a_abort_xfer_busy", 32'(aBusy), 32'd0);
      checkOutput("a_abort_xfer_wdata", 32'(aWdata), 32'h0005);
      checkOutput("a_abort_xfer_addr", 32'(aAddr), 32'd1);
      @(negedge clk);
      aAbort = 1'b0;
      byteValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("a_abort_after_we", 32'(aWe), 32'd0);

      // Asynchronous reset while waiting for a low byte, then a full reload
      $display("[TB] reset mid-session");
      pulseStart(1'b0);
      applyStimulus(1'b0, 8'h2A);
      byteValid = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkAllZeroA("midrst");
      checkOutput("b_done_reset", 32'(bDone), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulseStart(1'b0);
      for (int w = 0; w < 4; w++) begin
         applyStimulus(1'b0, 8'(w + 1));
         expA.push_back({10'(w), 6'(w + 1), 8'(8'h23 + 8'(w) * 8'h22)});
         applyStimulus(1'b0, 8'(8'h23 + 8'(w) * 8'h22));
      end
      byteValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("a_reload_done", 32'(aDone), 32'd1);

      repeat (2) @(negedge clk);
      checkOutput("a_sb_drained", 32'(expA.size()), 32'd0);
      checkOutput("b_sb_drained", 32'(expB.size()), 32'd0);
      checkOutput("b_we_count", 32'(bWeCount), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-stream program loader for the 14-bit instruction memory; the packing direction of the instruction field split. It accepts a stream of bytes over a valid/ready handshake, reassembles each pair into a 14-bit instruction word {B13, B12, B11, D[10:0]} and writes it to consecutive program-memory addresses. It sits between the host byte link (UART/SPI receiver) and the program memory write port, and is active only while the core is held out of execution.

## Interface

Parameters:
- ADDR_W, 10, program memory address width
- PROG_LEN, 1024, number of words loaded per session; 1 ≤ PROG_LEN ≤ 2^ADDR_W

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  single-cycle pulse, begins a load session (honoured in IDLE, DONE, ERR only)
- abort  in  1  level; returns to IDLE from any state, no further writes
- byte_in  in  8  incoming byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  program memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  14  instruction word: [13]=B13, [12]=B12, [11]=B11, [10:0]=D
- busy  out  1  session in progress (HI, LO, WRITE)
- done  out  1  PROG_LEN words written; held until next start or reset
- err  out  1  framing error; held until next start or reset

## Operation

- Byte format, per instruction, high byte first:
  - high byte: [7:6] reserved, must be 00; [5]=B13, [4]=B12, [3]=B11, [2:0]=D[10:8]
  - low byte: [7:0]=D[7:0]
- Transfer occurs on a rising edge where byte_valid & byte_ready. byte_in is ignored otherwise.
- FSM states: IDLE, HI, LO, WRITE, DONE, ERR.
  - IDLE: byte_ready=0. start → HI; mem_addr←0, done←0, err←0.
  - HI: byte_ready=1. On transfer: if byte_in[7:6]≠00 → ERR (err←1, nothing written); else hi_reg←byte_in[5:0] → LO.
  - LO: byte_ready=1. On transfer: mem_wdata←{hi_reg, byte_in} → WRITE.
  - WRITE: byte_ready=0, mem_we=1 for exactly this cycle at current mem_addr. Next: if mem_addr==PROG_LEN-1 → DONE (done←1); else mem_addr←mem_addr+1 → HI.
  - DONE: done=1, busy=0. start → HI as from IDLE.
  - ERR: err=1, busy=0, byte_ready=0. start → HI as from IDLE.
- abort: takes priority over every transition including start; next state IDLE; mem_we not asserted in the abort cycle's successor; done/err cleared; mem_addr and mem_wdata retain values.
- start while busy: ignored.
- mem_addr never wraps: the final write is at PROG_LEN-1 and the FSM leaves to DONE; the increment is never performed from PROG_LEN-1.
- mem_we is a Moore decode of WRITE; mem_addr and mem_wdata are registers, stable for the whole WRITE cycle.
- busy = state ∈ {HI, LO, WRITE}.

## Timing

- Reset (asynchronous, immediate): state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, hi_reg=0.
- start pulse at edge t → busy=1, byte_ready=1 from cycle after t.
- Low byte accepted at edge k → mem_we=1 during cycle k+1 → write committed by memory at edge k+2.
- Peak throughput: one word per 3 cycles (HI, LO, WRITE) with byte_valid held high.
- byte_valid may drop at any point; loader waits in HI/LO indefinitely, no timeout.
- Error detected on high-byte transfer at edge k → err=1, busy=0 from cycle k+1.
- Final WRITE cycle followed by done=1, busy=0 in the next cycle.

## Test plan

- Reset mid-session (in LO after 1 high byte): assert reset → all outputs zero immediately, no mem_we; later start reloads from addr 0.
- Single word, PROG_LEN=1: start, bytes 0x2F, 0xA5 with continuous valid → exactly one mem_we, mem_addr=0, mem_wdata=14'h2FA5 (B13=1, B12=0, B11=1, D=0x7A5); done=1 the next cycle, busy=0.
- Full load, PROG_LEN=4, bytes 0x00,0x01 / 0x07,0xFF / 0x38,0x00 / 0x3F,0xFF with gaps in byte_valid → writes 0x0001@0, 0x07FF@1, 0x3800@2, 0x3FFF@3; four mem_we pulses, 3-cycle spacing when no gaps; done=1 after.
- Framing error: second word high byte 0x40 → first word written at 0, no second write, err=1, byte_ready=0; start → err=0, mem_addr=0, new session accepts bytes.
- Abort: abort in LO and in WRITE cycle-predecessor → next state IDLE, no mem_we after abort cycle, byte_ready=0; start during busy (HI) ignored, mem_addr unchanged.
- Backpressure/ignore: byte_valid toggling with byte_ready=0 in IDLE, DONE, ERR → no state change, no writes; start in DONE restarts at addr 0 with done cleared.
